// File: rtl/rs_alu_station.sv
// ALU reservation station: buffers renamed ALU instructions until both
// physical sources are woken, then issues the lowest-index ready entry.

package rs_alu_pkg;
  localparam int unsigned RS_ALU_SIZE   = 8;
  localparam int unsigned PHYS_REG_BITS = 6;
  localparam int unsigned ROB_TAG_BITS  = 5;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned ALU_OP_BITS   = 4;

  typedef enum logic [1:0] {FU_ALU, FU_BRANCH, FU_LSU, FU_MUL} fu_type_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [ALU_OP_BITS-1:0]   alu_op;
    logic                     alu_src;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic [XLEN-1:0]          immediate;
    logic [ROB_TAG_BITS-1:0]  rob_tag;
  } renamed_instr_t;

  typedef struct packed {
    logic                     valid;
    logic                     ready;
    logic                     prs1_ready;
    logic                     prs2_ready;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [XLEN-1:0]          immediate;
    logic [ALU_OP_BITS-1:0]   alu_op;
    logic                     alu_src;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
    logic [ROB_TAG_BITS-1:0]  rob_tag;
    logic [XLEN-1:0]          pc;
  } rs_entry_t;
endpackage

module rs_alu_station
  import rs_alu_pkg::*;
#(
  parameter int unsigned DEPTH    = RS_ALU_SIZE,
  parameter int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  renamed_instr_t           dispatch_instr,
  input  logic                     dispatch_prs1_ready,
  input  logic                     dispatch_prs2_ready,
  input  logic                     cdb_valid,
  input  logic [PHYS_REG_BITS-1:0] cdb_prd,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output rs_entry_t                issue_entry,
  output logic [CNT_BITS-1:0]      count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t           entries      [DEPTH];
  rs_entry_t           entries_next [DEPTH];
  rs_entry_t           new_entry;
  logic [DEPTH-1:0]    valid_vec;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic                accept;
  logic                fire;
  logic [CNT_BITS-1:0] count_next;

  // Lowest free slot and lowest valid-and-ready slot
  always_comb begin
    valid_vec = '0;
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      valid_vec[i] = entries[i].valid;
      if (!entries[i].valid) begin
        free_idx = IDX_W'(i);
      end
      if (entries[i].valid && entries[i].ready) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Handshakes and issue payload, all from current state
  always_comb begin
    dispatch_ready = ~&valid_vec;
    issue_valid    = sel_found & ~flush;
    issue_entry    = issue_valid ? entries[sel_idx] : '0;
    accept         = dispatch_valid & dispatch_ready & ~flush;
    fire           = issue_valid & issue_ready;
  end

  // Incoming entry, capturing a broadcast that coincides with dispatch
  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.prs1       = dispatch_instr.prs1;
    new_entry.prs2       = dispatch_instr.prs2;
    new_entry.prd        = dispatch_instr.prd;
    new_entry.immediate  = dispatch_instr.immediate;
    new_entry.alu_op     = dispatch_instr.alu_op;
    new_entry.alu_src    = dispatch_instr.alu_src;
    new_entry.mem_read   = dispatch_instr.mem_read;
    new_entry.mem_write  = dispatch_instr.mem_write;
    new_entry.reg_write  = dispatch_instr.reg_write;
    new_entry.rob_tag    = dispatch_instr.rob_tag;
    new_entry.pc         = dispatch_instr.pc;
    new_entry.prs1_ready = dispatch_prs1_ready
                         | (cdb_valid && cdb_prd == dispatch_instr.prs1)
                         | (dispatch_instr.prs1 == '0);
    new_entry.prs2_ready = dispatch_prs2_ready
                         | (cdb_valid && cdb_prd == dispatch_instr.prs2)
                         | (dispatch_instr.prs2 == '0)
                         | dispatch_instr.alu_src;
    new_entry.ready      = new_entry.prs1_ready & new_entry.prs2_ready;
  end

  // Next entry state: wakeup, then issue free, then dispatch write
  always_comb begin
    entries_next = entries;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entries[i].valid && cdb_valid) begin
        if (cdb_prd == entries[i].prs1) entries_next[i].prs1_ready = 1'b1;
        if (cdb_prd == entries[i].prs2) entries_next[i].prs2_ready = 1'b1;
      end
      entries_next[i].ready = entries_next[i].prs1_ready & entries_next[i].prs2_ready;
    end
    if (fire) begin
      entries_next[sel_idx] = '0;
    end
    if (accept) begin
      entries_next[free_idx] = new_entry;
    end
    count_next = count + CNT_BITS'(accept) - CNT_BITS'(fire);
  end

  // State registers; flush squashes everything including same-cycle traffic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries <= '{default: '0};
      count   <= '0;
    end else if (flush) begin
      entries <= '{default: '0};
      count   <= '0;
    end else begin
      entries <= entries_next;
      count   <= count_next;
    end
  end

endmodule
